// File: rtl/pipe_pkg.sv
// Shared definitions for the IF/DEC pipeline stage: bubble encoding, stage
// occupancy states and the default-width instruction payload.
package pipe_pkg;

   localparam int INSTR_W_DEF = 32;
   localparam int PC_W_DEF    = 32;

   // MIPS sll $0,$0,0 -- the canonical NOP used as the bubble instruction.
   localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stage_state_t;

   typedef struct packed {
      logic [INSTR_W_DEF-1:0] instr;
      logic [PC_W_DEF-1:0]    pcplus4;
   } ifdec_payload_t;

endpackage

// File: rtl/pipe_stage_skid.sv
// IF/DEC pipeline register with valid/ready handshake and a one-entry skid slot,
// so decode backpressure never reaches fetch through combinational logic.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int                 INSTR_W   = 32,
   parameter int                 PC_W      = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
   parameter int                 CNT_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pcplus4,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pcplus4,
   output logic [CNT_W-1:0]   stall_cnt
);

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pcplus4;
   } payload_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   stage_state_t     state, state_nxt;
   payload_t         main_q, main_nxt;
   payload_t         skid_q, skid_nxt;
   payload_t         in_payload;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             accept, retire;

   assign in_payload = payload_t'{instr: in_instr, pcplus4: in_pcplus4};
   assign stall_cnt  = cnt_q;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_nxt   = state;
      main_nxt    = main_q;
      skid_nxt    = skid_q;
      cnt_nxt     = cnt_q;

      // Both handshake outputs depend on the state register alone, never on out_ready.
      out_valid   = (state != EMPTY);
      in_ready    = (state != FULL);
      accept      = in_valid & in_ready;
      retire      = out_valid & out_ready;

      if (out_valid && !out_ready && (cnt_q != CNT_MAX)) begin
         cnt_nxt = cnt_q + CNT_W'(1);
      end

      unique case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt = ONE;
               main_nxt  = in_payload;
            end
         end
         ONE: begin
            if (accept && retire) begin
               main_nxt  = in_payload;
            end else if (accept) begin
               state_nxt = FULL;
               skid_nxt  = in_payload;
            end else if (retire) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (retire) begin
               state_nxt = ONE;
               main_nxt  = skid_q;
            end
         end
         default: state_nxt = EMPTY;
      endcase

      // A redirect discards everything held, including a same-cycle accept.
      if (flush) begin
         state_nxt = EMPTY;
      end

      out_instr   = out_valid ? main_q.instr   : NOP_INSTR;
      out_pcplus4 = out_valid ? main_q.pcplus4 : '0;
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so every reader sees pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= EMPTY;
         // NOTE: the payload slots are reset with the rest because they share this block; outputs are gated anyway.
         main_q <= '0;
         skid_q <= '0;
         cnt_q  <= '0;
      end else begin
         state  <= state_nxt;
         main_q <= main_nxt;
         skid_q <= skid_nxt;
         cnt_q  <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus a random stream, checked by a
// scoreboard queue that a separate negedge monitor drains on every retire.
module tb_pipe_stage_skid;
   import pipe_pkg::*;

   localparam int          CNT_W   = 4;
   localparam int          CNT_SAT = (1 << CNT_W) - 1;
   localparam logic [31:0] NOP     = 32'h0000_0000;

   logic             clk        = 1'b0;
   logic             reset      = 1'b1;
   logic             flush      = 1'b0;
   logic             in_valid   = 1'b0;
   logic             out_ready  = 1'b0;
   logic [31:0]      in_instr   = '0;
   logic [31:0]      in_pcplus4 = '0;
   logic             in_ready;
   logic             out_valid;
   logic [31:0]      out_instr;
   logic [31:0]      out_pcplus4;
   logic [CNT_W-1:0] stall_cnt;

   int             errors  = 0;
   int             checks  = 0;
   int             exp_cnt = 0;
   bit             mon_en  = 1'b0;
   bit             exp_valid;
   ifdec_payload_t exp_pl;
   ifdec_payload_t sb_q[$];

   pipe_stage_skid #(
      .INSTR_W  (32),
      .PC_W     (32),
      .NOP_INSTR(NOP),
      .CNT_W    (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .in_pcplus4 (in_pcplus4),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_pcplus4(out_pcplus4),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares the DUT against the scoreboard every cycle, pops on retire.
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         exp_valid = (sb_q.size() != 0);
         check("mon_out_valid", out_valid, exp_valid);
         check("mon_in_ready", in_ready, sb_q.size() < 2);
         check("mon_stall_cnt", stall_cnt, exp_cnt);
         if (!out_valid) begin
            check("mon_bubble_instr", out_instr, NOP);
            check("mon_bubble_pc", out_pcplus4, 0);
         end
         if (exp_valid && out_ready) begin
            exp_pl = sb_q.pop_front();
            check("mon_retire_instr", out_instr, exp_pl.instr);
            check("mon_retire_pc", out_pcplus4, exp_pl.pcplus4);
         end
         if (exp_valid && !out_ready && exp_cnt < CNT_SAT) exp_cnt++;
      end
   end

   // Called and returning at posedge+1; pushes the expected entry on accept.
   task automatic cycle(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                        input bit ordy, input bit fl);
      bit will_acc;
      in_valid   = v;
      in_instr   = instr;
      in_pcplus4 = pc;
      out_ready  = ordy;
      flush      = fl;
      will_acc   = v && (sb_q.size() < 2) && !fl;
      @(negedge clk);
      #1;
      if (fl) sb_q.delete();
      else if (will_acc) sb_q.push_back(ifdec_payload_t'{instr: instr, pcplus4: pc});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      sb_q.delete();
      exp_cnt   = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset     = 1'b0;
   endtask

   initial begin
      do_reset();
      mon_en = 1'b1;
      check("reset_out_valid", out_valid, 0);
      check("reset_out_instr", out_instr, NOP);
      check("reset_in_ready", in_ready, 1);
      check("reset_stall_cnt", stall_cnt, 0);

      // Reset asserted while FULL clears outputs immediately.
      cycle(1, 32'hAA, 32'h1004, 0, 0);
      cycle(1, 32'hBB, 32'h1008, 0, 0);
      check("full_in_ready", in_ready, 0);
      check("full_stall_cnt", stall_cnt, 1);
      #3;
      reset = 1'b1;
      sb_q.delete();
      exp_cnt = 0;
      #1;
      check("midreset_out_valid", out_valid, 0);
      check("midreset_out_instr", out_instr, NOP);
      check("midreset_in_ready", in_ready, 1);
      check("midreset_stall_cnt", stall_cnt, 0);
      do_reset();

      // Streaming with out_ready held high.
      for (int i = 0; i < 4; i++) begin
         cycle(1, 32'h2008_0001 + i, 32'h0040_0004 + 4 * i, 1, 0);
         check("stream_out_instr", out_instr, 32'h2008_0001 + i);
         check("stream_out_pc", out_pcplus4, 32'h0040_0004 + 4 * i);
         check("stream_in_ready", in_ready, 1);
      end
      cycle(0, 0, 0, 1, 0);
      check("stream_drained", out_valid, 0);

      // Backpressure fills the skid slot, then drains in order.
      do_reset();
      cycle(1, 32'h11, 32'h2004, 0, 0);
      cycle(1, 32'h22, 32'h2008, 0, 0);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_instr", out_instr, 32'h11);
      check("bp_stall_cnt", stall_cnt, 1);
      cycle(0, 0, 0, 1, 0);
      check("bp_second_instr", out_instr, 32'h22);
      check("bp_second_pc", out_pcplus4, 32'h2008);
      check("bp_in_ready_back", in_ready, 1);
      cycle(0, 0, 0, 1, 0);
      check("bp_empty", out_valid, 0);
      check("bp_stall_final", stall_cnt, 1);

      // Flush in FULL with a same-cycle input: input dropped, counter kept.
      cycle(1, 32'h11, 32'h3004, 0, 0);
      cycle(1, 32'h22, 32'h3008, 0, 0);
      check("fl_pre_stall", stall_cnt, 2);
      cycle(1, 32'h33, 32'h300C, 1, 1);
      check("fl_out_valid", out_valid, 0);
      check("fl_out_instr", out_instr, NOP);
      check("fl_out_pc", out_pcplus4, 0);
      check("fl_in_ready", in_ready, 1);
      check("fl_stall_kept", stall_cnt, 2);
      cycle(0, 0, 0, 1, 0);
      check("fl_input_dropped", out_valid, 0);

      // Counter saturation at 2^CNT_W-1.
      do_reset();
      cycle(1, 32'h55, 32'h4004, 0, 0);
      repeat (20) cycle(0, 0, 0, 0, 0);
      check("sat_stall_cnt", stall_cnt, 15);
      cycle(0, 0, 0, 0, 0);
      check("sat_stall_hold", stall_cnt, 15);
      check("sat_out_instr", out_instr, 32'h55);
      cycle(0, 0, 0, 1, 0);

      // Random traffic against the scoreboard.
      do_reset();
      for (int i = 0; i < 10000; i++) begin
         cycle($urandom_range(0, 99) < 60, $urandom, $urandom,
               $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3);
      end
      repeat (3) cycle(0, 0, 0, 1, 0);
      check("rand_drain_empty", sb_q.size(), 0);
      check("rand_out_valid", out_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
